// File: rtl/pipe_muxn.sv
// N-way WIDTH-bit select mux with one registered output stage, stall/flush control,
// valid tracking and sticky out-of-range select reporting with a saturating count.
module pipe_muxn #(
  parameter int WIDTH = 32,
  parameter int N     = 5,
  parameter int SELW  = 3,
  parameter int CNTW  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [SELW-1:0]      s,
  input  logic [N*WIDTH-1:0]   d,
  input  logic                 err_clr,
  output logic [WIDTH-1:0]     y,
  output logic                 y_valid,
  output logic [SELW-1:0]      y_sel,
  output logic                 sel_err,
  output logic [CNTW-1:0]      err_cnt
);

  logic [N-1:0]     hit;
  logic [WIDTH-1:0] sel_data;
  logic             in_range;
  logic             take;
  logic             oor;
  logic [CNTW-1:0]  cnt_inc;

  // One comparator per input, AND-OR combined: no priority chain, and an
  // out-of-range select yields no hit, so sel_data is 0 rather than X.
  always_comb begin
    hit      = '0;
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      hit[k]   = (s == SELW'(k));
      sel_data = sel_data | ({WIDTH{hit[k]}} & d[k*WIDTH +: WIDTH]);
    end
  end

  assign in_range = |hit;
  assign take     = in_valid & in_range;
  assign oor      = in_valid & ~in_range;
  assign cnt_inc  = (&err_cnt) ? err_cnt : err_cnt + CNTW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y       <= '0;
      y_valid <= 1'b0;
      y_sel   <= '0;
      sel_err <= 1'b0;
      err_cnt <= '0;
    end else if (flush) begin
      y_valid <= 1'b0;
      if (err_clr) begin
        sel_err <= 1'b0;
        err_cnt <= '0;
      end
    end else if (en) begin
      y_valid <= take;
      if (take) begin
        y     <= sel_data;
        y_sel <= s;
      end
      // A clear coinciding with an error event is applied first, leaving a count of one.
      if (oor) begin
        sel_err <= 1'b1;
        err_cnt <= err_clr ? CNTW'(1) : cnt_inc;
      end else if (err_clr) begin
        sel_err <= 1'b0;
        err_cnt <= '0;
      end
    end
  end

endmodule

// File: doc/pipe_muxn.md
Name: pipe_muxn

Overview:
Parametrised N-way, WIDTH-bit select multiplexer with a registered output stage. It is the pipelined successor to the combinational result/forwarding selects in the datapath. It sits at pipeline-stage boundaries (for example the writeback result select) and adds:
- stall (enable) and flush control
- valid tracking
- defined hold behaviour for out-of-range selects
- sticky error reporting with a saturating error count

Parameters:
WIDTH, 32, data width of each input and of the output
N, 5, number of data inputs; legal range 2..2**SELW
SELW, 3, select width; must be at least clog2(N)
CNTW, 8, width of the out-of-range error counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
en  input  1  stage enable; 0 = stall, all state holds
flush  input  1  kill the stage: invalidate the output, no capture
in_valid  input  1  current select/data are meaningful
s  input  SELW  select index
d  input  N*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH]
err_clr  input  1  clears sel_err and err_cnt
y  output  WIDTH  registered selected data
y_valid  output  1  y holds a freshly captured legal selection
y_sel  output  SELW  index that produced the current y
sel_err  output  1  sticky flag: a valid out-of-range select occurred
err_cnt  output  CNTW  saturating count of valid out-of-range selects

Behaviour:
- Reset (asynchronous, active-high): y=0, y_valid=0, y_sel=0, sel_err=0, err_cnt=0. Reset overrides every other input and takes effect immediately, not at the next edge. After deassertion, operation resumes on the next rising edge.
- Latency: exactly 1 cycle. Inputs sampled at edge t appear on y / y_valid after edge t.
- Priority at each edge (highest first): reset > flush > en=0 > normal capture.
- flush=1 (en ignored):
  - y_valid<=0; y and y_sel hold.
  - No error detection and no counting.
  - err_clr is still honoured.
- en=0, flush=0:
  - y, y_valid, y_sel, sel_err and err_cnt all hold.
  - err_clr is ignored while stalled.
- en=1, flush=0, in_valid=0: y_valid<=0; y and y_sel hold.
- en=1, flush=0, in_valid=1, s<N: y<=d[s], y_sel<=s, y_valid<=1.
- en=1, flush=0, in_valid=1, s>=N (out of range):
  - y and y_sel hold; y_valid<=0.
  - sel_err<=1; err_cnt<=err_cnt+1, saturating at 2**CNTW-1 (no wrap).
  - No latch or X is permitted: y never takes an undefined value.
- err_clr=1 with no simultaneous error event: sel_err<=0, err_cnt<=0.
- err_clr=1 with a simultaneous out-of-range event: clear applies first, then the event. Result: sel_err=1, err_cnt=1.
- When N=2**SELW, out-of-range is impossible; sel_err and err_cnt stay 0.
- Select decode is a full parallel compare (no priority chain). Simultaneous changes of s and d within a cycle have no effect until the edge.
- Fully synchronous except reset; a single clock domain; no combinational path from inputs to outputs.

Test Plan:
1. Reset then capture (defaults): assert reset mid-cycle with y=0xDEADBEEF held → y=0, y_valid=0, err_cnt=0 immediately, before the next edge. Release reset; d0..d4=0x10,0x20,0x30,0x40,0x50, s=3, en=1, in_valid=1 → after 1 edge y=0x40, y_sel=3, y_valid=1.
2. Stall/flush: after y=0x40, set en=0, s=1 for 3 edges → y=0x40 and y_valid=1 unchanged. Then flush=1, en=0 → y_valid=0, y=0x40. Then en=1, flush=0, s=1 → y=0x20, y_valid=1.
3. Out-of-range: s=6, in_valid=1, en=1 for 2 edges → y holds the prior 0x20, y_valid=0, sel_err=1, err_cnt=2. Then s=6 with in_valid=0 → err_cnt stays 2.
4. Saturation and clear: CNTW=2, apply s=7 valid for 5 edges → err_cnt=3 (saturated, no wrap). err_clr alone → sel_err=0, err_cnt=0. err_clr together with s=5 valid → sel_err=1, err_cnt=1.
5. Generalisation: WIDTH=16, N=8, SELW=3; sweep s=0..7 with d[k]=0x1000+k → y=0x1000+k one edge later for every k; sel_err never asserts.
6. Flush vs error: flush=1 with s=7, in_valid=1 → sel_err stays 0, err_cnt unchanged, y_valid=0.
